// File: rtl/cal_field_counter.sv
// -----------------------------------------------------------------------------
// cal_field_counter
//   Generic calendar-field counter (seconds, minutes, hours, days, months,
//   years). In run mode it advances on carry_in from the lower field and emits
//   a registered one-cycle carry_out when it wraps. In setup mode the user
//   steps it up or down with wrap-around. The upper limit is either the static
//   MAX_VAL or the dynamic dyn_max (e.g. days-in-month). Any value outside
//   [MIN_VAL, eff_max] is pulled back into range on the next edge.
//
//   Optional feature, enabled by defining CAL_FIELD_AUTO_REPEAT_EN:
//     tick is treated as a held button level. One step is issued on its rising
//     edge. After HOLD_CYC cycles, further steps follow every RPT_CYC cycles.
//   Without the macro, every cycle with tick high is exactly one step.
// -----------------------------------------------------------------------------
module cal_field_counter #(
    parameter int unsigned WIDTH     = 6,
    parameter int unsigned MIN_VAL   = 1,
    parameter int unsigned MAX_VAL   = 12,
    parameter int unsigned RESET_VAL = 1,
    parameter int unsigned HOLD_CYC  = 8,
    parameter int unsigned RPT_CYC   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             display,
    input  logic             setup_sel,
    input  logic             tick,
    input  logic             inc_dec,
    input  logic             carry_in,
    input  logic             use_dyn_max,
    input  logic [WIDTH-1:0] dyn_max,
    output logic [WIDTH-1:0] value,
    output logic             carry_out
);

    localparam logic [WIDTH-1:0] MIN_V   = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE_V   = WIDTH'(1);

    // Reject parameter sets that cannot describe a sensible field.
    if (HOLD_CYC == 0 || RPT_CYC == 0 || MIN_VAL > MAX_VAL) begin : g_bad_cfg
        $error("cal_field_counter: illegal parameter set");
    end

    // -------------------------------------------------------------------------
    // Value and carry state
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] value_q, value_d;
    logic             carry_out_q, carry_out_d;
    logic [WIDTH-1:0] eff_max;
    logic             above_max;
    logic             below_min;
    logic             step;     // one setup-mode step request this cycle

    assign eff_max   = use_dyn_max ? dyn_max : MAX_V;
    assign above_max = (value_q > eff_max);

    // With MIN_VAL == 0 nothing unsigned can sit below it, so no comparator.
    if (MIN_VAL == 0) begin : g_min_zero
        assign below_min = 1'b0;
    end else begin : g_min_nonzero
        assign below_min = (value_q < MIN_V);
    end

`ifdef CAL_FIELD_AUTO_REPEAT_EN
    // -------------------------------------------------------------------------
    // Auto-repeat for a held tick button
    // -------------------------------------------------------------------------
    localparam int unsigned CNT_MAX = (HOLD_CYC > RPT_CYC) ? HOLD_CYC : RPT_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(RPT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        RPT_IDLE = 2'd0,   // button released or not editing this field
        RPT_HOLD = 2'd1,   // first step issued, waiting for the hold delay
        RPT_RUN  = 2'd2    // repeating every RPT_CYC cycles
    } rpt_state_t;

    rpt_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Next-state and step generation for the repeat FSM.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        tick_d  = tick;
        step    = 1'b0;

        if (!tick || !display || !setup_sel) begin
            // Releasing the button or leaving this field's edit cancels repeat.
            state_d = RPT_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                RPT_IDLE: begin
                    if (!tick_q) begin
                        step    = 1'b1;
                        state_d = RPT_HOLD;
                        cnt_d   = '0;
                    end
                end
                RPT_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        step    = 1'b1;
                        state_d = RPT_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                RPT_RUN: begin
                    if (cnt_q == RPT_LAST) begin
                        step  = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = RPT_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Repeat FSM registers, tick edge detector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RPT_IDLE;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
        end
    end
`else
    // Pulse mode: each cycle with tick high is one step.
    always_comb begin
        step = tick;
    end
`endif

    // -------------------------------------------------------------------------
    // Next value: range fix, then run advance, then setup step, else hold
    // -------------------------------------------------------------------------
    // Compute next value and carry with the fixed priority order.
    always_comb begin
        value_d     = value_q;
        carry_out_d = 1'b0;

        if (above_max) begin
            // Limit dropped under us; clamp and drop this cycle's strobes.
            value_d = eff_max;
        end else if (below_min) begin
            value_d = MIN_V;
        end else if (!display) begin
            // Run mode: only carry_in matters.
            if (carry_in) begin
                if (value_q == eff_max) begin
                    value_d     = MIN_V;
                    carry_out_d = 1'b1;
                end else begin
                    value_d = value_q + ONE_V;
                end
            end
        end else if (setup_sel && step) begin
            // Setup mode: wrap in both directions, never a carry.
            if (inc_dec) begin
                value_d = (value_q == eff_max) ? MIN_V : (value_q + ONE_V);
            end else begin
                value_d = (value_q == MIN_V) ? eff_max : (value_q - ONE_V);
            end
        end
    end

    // Value and carry registers; reset asserts asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            value_q     <= RESET_V;
            carry_out_q <= 1'b0;
        end else begin
            value_q     <= value_d;
            carry_out_q <= carry_out_d;
        end
    end

    assign value     = value_q;
    assign carry_out = carry_out_q;

endmodule

// File: tb/tb_cal_field_counter.sv
// -----------------------------------------------------------------------------
// tb_cal_field_counter
//   Two instances: dut_a (MIN 1, MAX 12, reset 1) and dut_b (MIN 0, MAX 59,
//   reset 0). Stimulus pushes hand-computed expectations into a scoreboard
//   queue tagged with the cycle they apply to; a monitor pops and compares on
//   the falling edge (or immediately, for the asynchronous reset check).
// -----------------------------------------------------------------------------
module tb_cal_field_counter;

    typedef struct {
        string       name;
        int unsigned due;
        bit          which;     // 0 = dut_a, 1 = dut_b
        logic [5:0]  val;
        logic        carry;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;

    logic       a_display, a_sel, a_tick, a_inc, a_cin, a_dyn_en;
    logic [5:0] a_dyn, a_value;
    logic       a_carry;

    logic       b_display, b_sel, b_tick, b_inc, b_cin, b_dyn_en;
    logic [5:0] b_dyn, b_value;
    logic       b_carry;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    event        chk_now;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    cal_field_counter #(
        .WIDTH(6), .MIN_VAL(1), .MAX_VAL(12), .RESET_VAL(1), .HOLD_CYC(8), .RPT_CYC(2)
    ) dut_a (
        .clk(clk), .rst(rst), .display(a_display), .setup_sel(a_sel), .tick(a_tick),
        .inc_dec(a_inc), .carry_in(a_cin), .use_dyn_max(a_dyn_en), .dyn_max(a_dyn),
        .value(a_value), .carry_out(a_carry)
    );

    cal_field_counter #(
        .WIDTH(6), .MIN_VAL(0), .MAX_VAL(59), .RESET_VAL(0), .HOLD_CYC(8), .RPT_CYC(2)
    ) dut_b (
        .clk(clk), .rst(rst), .display(b_display), .setup_sel(b_sel), .tick(b_tick),
        .inc_dec(b_inc), .carry_in(b_cin), .use_dyn_max(b_dyn_en), .dyn_max(b_dyn),
        .value(b_value), .carry_out(b_carry)
    );

    // Compare one scoreboard entry against the selected DUT.
    task automatic check(input exp_t e);
        logic [5:0] av;
        logic       ac;
        av = e.which ? b_value : a_value;
        ac = e.which ? b_carry : a_carry;
        n_checks++;
        if (av === e.val && ac === e.carry) n_pass++;
        else $display("FAIL %s: got value=%0d carry=%b, expected value=%0d carry=%b",
                      e.name, av, ac, e.val, e.carry);
    endtask

    // Monitor: drain every entry that is due by now.
    initial begin
        forever begin
            @(negedge clk or chk_now);
            while (sb.size() != 0 && sb[0].due <= cyc) begin
                check(sb.pop_front());
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic edge_sync();
        @(posedge clk);
        #1;
    endtask

    // Expectation for the state visible after the edge just passed.
    task automatic expect_v(input bit which, input string name, input logic [5:0] v,
                            input logic c);
        exp_t e;
        e.name = name; e.due = cyc; e.which = which; e.val = v; e.carry = c;
        sb.push_back(e);
    endtask

    // One setup step (single-cycle tick) followed by one idle cycle.
    task automatic setup_step(input bit which, input logic inc, input logic [5:0] v,
                              input string name);
        if (which) begin
            b_display = 1'b1; b_sel = 1'b1; b_inc = inc; b_tick = 1'b1;
        end else begin
            a_display = 1'b1; a_sel = 1'b1; a_inc = inc; a_tick = 1'b1;
        end
        edge_sync();
        if (which) b_tick = 1'b0; else a_tick = 1'b0;
        expect_v(which, name, v, 1'b0);
        edge_sync();
        expect_v(which, {name, "_hold"}, v, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        a_display = 0; a_sel = 0; a_tick = 0; a_inc = 0; a_cin = 0; a_dyn_en = 0; a_dyn = 6'd0;
        b_display = 0; b_sel = 0; b_tick = 0; b_inc = 0; b_cin = 0; b_dyn_en = 0; b_dyn = 6'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        expect_v(0, "reset_a", 6'd1, 1'b0);
        expect_v(1, "reset_b", 6'd0, 1'b0);

        // Setup decrement from MIN wraps to MAX.
        setup_step(0, 1'b0, 6'd12, "a_dec_wrap");

        // T1: run-mode wrap with one-cycle carry pulse.
        a_display = 1'b0; a_cin = 1'b1;
        edge_sync(); a_cin = 1'b0;
        expect_v(0, "t1_wrap", 6'd1, 1'b1);
        edge_sync();
        expect_v(0, "t1_carry_one_cycle", 6'd1, 1'b0);

        // Back-to-back run advances.
        a_cin = 1'b1;
        edge_sync(); expect_v(0, "run_inc_2", 6'd2, 1'b0);
        edge_sync(); expect_v(0, "run_inc_3", 6'd3, 1'b0);
        edge_sync(); expect_v(0, "run_inc_4", 6'd4, 1'b0);
        a_cin = 1'b0;
        edge_sync(); expect_v(0, "run_hold", 6'd4, 1'b0);

        // T4: ignored strobes.
        a_display = 1'b0; a_sel = 1'b1; a_inc = 1'b1; a_tick = 1'b1;
        edge_sync(); a_tick = 1'b0;
        expect_v(0, "t4_tick_in_run", 6'd4, 1'b0);
        edge_sync();
        a_display = 1'b1; a_sel = 1'b0; a_tick = 1'b1;
        edge_sync(); a_tick = 1'b0;
        expect_v(0, "t4_tick_unselected", 6'd4, 1'b0);
        edge_sync();
        a_sel = 1'b1; a_cin = 1'b1;
        edge_sync(); a_cin = 1'b0;
        expect_v(0, "t4_cin_in_setup", 6'd4, 1'b0);
        edge_sync();
        expect_v(0, "t4_cin_not_queued", 6'd4, 1'b0);

        // Setup increments up to 7.
        setup_step(0, 1'b1, 6'd5, "a_inc_5");
        setup_step(0, 1'b1, 6'd6, "a_inc_6");
        setup_step(0, 1'b1, 6'd7, "a_inc_7");

        // T5: asynchronous reset between clock edges.
        @(posedge clk);
        #2; rst = 1'b1;
        #1;
        expect_v(0, "t5_async_rst", 6'd1, 1'b0);
        sb[sb.size()-1].due = 0;
        -> chk_now;
        edge_sync();
        rst = 1'b0;
        edge_sync();
        expect_v(0, "t5_after_release", 6'd1, 1'b0);

        // T3: dynamic max drops below value; same-cycle carry_in is dropped.
        a_dyn_en = 1'b1; a_dyn = 6'd31;
        setup_step(0, 1'b0, 6'd31, "t3_dec_to_dyn31");
        a_display = 1'b0; a_dyn = 6'd28; a_cin = 1'b1;
        edge_sync(); a_cin = 1'b0;
        expect_v(0, "t3_clamp_28", 6'd28, 1'b0);
        edge_sync();
        expect_v(0, "t3_clamp_hold", 6'd28, 1'b0);
        a_cin = 1'b1;
        edge_sync(); a_cin = 1'b0;
        expect_v(0, "t3_wrap_at_dyn", 6'd1, 1'b1);

        // MIN_VAL == eff_max: value pinned, run carry still pulses.
        a_dyn = 6'd1;
        edge_sync();
        expect_v(0, "eq_idle", 6'd1, 1'b0);
        a_cin = 1'b1;
        edge_sync(); a_cin = 1'b0;
        expect_v(0, "eq_run_carry", 6'd1, 1'b1);
        setup_step(0, 1'b1, 6'd1, "eq_setup_inc");
        setup_step(0, 1'b0, 6'd1, "eq_setup_dec");
        a_dyn_en = 1'b0;

`ifdef CAL_FIELD_AUTO_REPEAT_EN
        // T6: tick held 14 cycles from 1 -> steps at cycles 0, 8, 10, 12.
        a_display = 1'b1; a_sel = 1'b1; a_inc = 1'b1; a_tick = 1'b1;
        for (int k = 0; k < 14; k++) begin
            logic [5:0] ev;
            edge_sync();
            ev = (k < 8) ? 6'd2 : (k < 10) ? 6'd3 : (k < 12) ? 6'd4 : 6'd5;
            if (k == 13) a_tick = 1'b0;
            expect_v(0, $sformatf("t6_held_%0d", k), ev, 1'b0);
        end
        edge_sync();
        expect_v(0, "t6_released", 6'd5, 1'b0);
`else
        // Tick held high: one step per cycle.
        a_display = 1'b1; a_sel = 1'b1; a_inc = 1'b1; a_tick = 1'b1;
        edge_sync(); expect_v(0, "held_tick_2", 6'd2, 1'b0);
        edge_sync(); expect_v(0, "held_tick_3", 6'd3, 1'b0);
        edge_sync(); a_tick = 1'b0;
        expect_v(0, "held_tick_4", 6'd4, 1'b0);
        edge_sync(); expect_v(0, "held_tick_release", 6'd4, 1'b0);
`endif

        // T2 on the 0..59 field: wrap both ways in setup, no carry.
        setup_step(1, 1'b0, 6'd59, "t2_dec_wrap");
        setup_step(1, 1'b1, 6'd0, "t2_inc_wrap");
        setup_step(1, 1'b1, 6'd1, "t2_inc_1");
        setup_step(1, 1'b0, 6'd0, "t2_dec_0");
        b_display = 1'b0; b_cin = 1'b1;
        edge_sync(); b_cin = 1'b0;
        expect_v(1, "b_run_inc", 6'd1, 1'b0);
        edge_sync();
        expect_v(1, "b_run_hold", 6'd1, 1'b0);

        // Let the monitor drain, then confirm nothing is left unchecked.
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
